// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller:
// FSM state encoding, access-size codes and the store strobe helper.
package mem_pkg;

  // Controller states; two-bit encoding shared with anything that observes the FSM
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  // Access size codes carried on sizeM / data_size
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Byte strobes presented on the bus: loads never enable lanes
  function automatic logic [3:0] busStrobe(input logic isWrite, input logic [3:0] strb);
    return isWrite ? strb : 4'b0000;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response bus between the memory-stage controller and the data memory.
// The controller is the master: it issues requests and receives the handshakes.
interface mem_access_ctrl_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller. Latches one access from the pipeline,
// presents it on the bus until the address is accepted, waits for the data
// phase, captures load data and then parks in DONE until the pipeline moves on.
module mem_access_ctrl
  import mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               memenM,
  input  logic               memwriteM,
  input  logic [3:0]         sig_write,
  input  logic [1:0]         sizeM,
  input  logic [31:0]        aluoutM,
  input  logic [31:0]        writedataM,
  input  logic               stall_extM,
  mem_access_ctrl_if.master  memBus,
  output logic [31:0]        readdataM,
  output logic               stall_memM
);

  state_t      state;
  logic        busReq;
  logic        busWr;
  logic [1:0]  busSize;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busWstrb;

  // Bus request fields come straight from registers so they cannot glitch
  // while the slave is still deciding whether to accept the address.
  assign memBus.data_req   = busReq;
  assign memBus.data_wr    = busWr;
  assign memBus.data_size  = busSize;
  assign memBus.data_addr  = busAddr;
  assign memBus.data_wdata = busWdata;
  assign memBus.data_wstrb = busWstrb;

  // Stall covers the request cycle in IDLE plus every cycle an access is in
  // flight; reset forces it low even though state already reads IDLE.
  assign stall_memM = ~rst & (((state == IDLE) & memenM) |
                              (state == ADDR) | (state == DATA));

  // Access FSM: latch in IDLE, address phase in ADDR, data phase in DATA,
  // hold in DONE while the rest of the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busReq    <= 1'b0;
      busWr     <= 1'b0;
      busSize   <= SIZE_BYTE;
      busAddr   <= 32'h0;
      busWdata  <= 32'h0;
      busWstrb  <= 4'b0000;
      readdataM <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (memenM) begin
            busReq   <= 1'b1;
            busWr    <= memwriteM;
            busSize  <= sizeM;
            busAddr  <= aluoutM;
            busWdata <= writedataM;
            busWstrb <= busStrobe(memwriteM, sig_write);
            state    <= ADDR;
          end
        end
        ADDR: begin
          // Once issued the request runs to completion regardless of memenM
          if (memBus.data_addr_ok) begin
            busReq <= 1'b0;
            if (memBus.data_data_ok) begin
              if (!busWr) begin
                readdataM <= memBus.data_rdata;
              end
              state <= DONE;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (memBus.data_data_ok) begin
            if (!busWr) begin
              readdataM <= memBus.data_rdata;
            end
            state <= DONE;
          end
        end
        DONE: begin
          if (!stall_extM) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: word load, store with wait states,
// DONE hold, reset mid-transaction, memenM drop and back-to-back loads.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        memenM;
  logic        memwriteM;
  logic [3:0]  sig_write;
  logic [1:0]  sizeM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic        stall_extM;
  logic [31:0] readdataM;
  logic        stall_memM;

  int compared;
  int mismatched;
  int stallCnt;

  mem_access_ctrl_if memBus ();

  mem_access_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .memenM     (memenM),
    .memwriteM  (memwriteM),
    .sig_write  (sig_write),
    .sizeM      (sizeM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .stall_extM (stall_extM),
    .memBus     (memBus),
    .readdataM  (readdataM),
    .stall_memM (stall_memM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1ns past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st();
    return {30'h0, dut.state};
  endfunction

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    memenM     = 1'b1;
    memwriteM  = 1'b0;
    sig_write  = 4'b0000;
    sizeM      = 2'd0;
    aluoutM    = 32'h0;
    writedataM = 32'h0;
    stall_extM = 1'b0;
    memBus.data_addr_ok = 1'b0;
    memBus.data_data_ok = 1'b0;
    memBus.data_rdata   = 32'h0;

    // Reset state
    step();
    step();
    #1;
    chk("rst_state", st(), 32'd0);
    chk("rst_req", memBus.data_req, 32'd0);
    chk("rst_stall", stall_memM, 32'd0);
    chk("rst_rdata", readdataM, 32'd0);
    chk("rst_addr", memBus.data_addr, 32'd0);
    memenM = 1'b0;
    step();
    rst = 1'b0;

    // Word load, both oks in the same cycle
    step();
    stallCnt   = 0;
    memenM     = 1'b1;
    memwriteM  = 1'b0;
    sig_write  = 4'hF;
    sizeM      = SIZE_WORD;
    aluoutM    = 32'h8000_0010;
    memBus.data_addr_ok = 1'b1;
    memBus.data_data_ok = 1'b1;
    memBus.data_rdata   = 32'hDEAD_BEEF;
    #1;
    chk("ld_idle_stall", stall_memM, 32'd1);
    chk("ld_idle_req", memBus.data_req, 32'd0);
    chk("ld_idle_rd", readdataM, 32'd0);
    if (stall_memM) stallCnt++;
    step();
    if (stall_memM) stallCnt++;
    chk("ld_addr_state", st(), 32'd1);
    chk("ld_req", memBus.data_req, 32'd1);
    chk("ld_addr", memBus.data_addr, 32'h8000_0010);
    chk("ld_wr", memBus.data_wr, 32'd0);
    chk("ld_wstrb", memBus.data_wstrb, 32'd0);
    chk("ld_size", memBus.data_size, 32'd2);
    step();
    if (stall_memM) stallCnt++;
    chk("ld_done_state", st(), 32'd3);
    chk("ld_rdata", readdataM, 32'hDEAD_BEEF);
    chk("ld_done_req", memBus.data_req, 32'd0);
    memenM = 1'b0;
    memBus.data_addr_ok = 1'b0;
    memBus.data_data_ok = 1'b0;
    step();
    if (stall_memM) stallCnt++;
    chk("ld_stall_cycles", stallCnt, 32'd2);
    chk("ld_back_idle", st(), 32'd0);

    // Store with wait states
    memenM     = 1'b1;
    memwriteM  = 1'b1;
    sig_write  = 4'b0011;
    sizeM      = SIZE_HALF;
    aluoutM    = 32'h8000_0020;
    writedataM = 32'h0000_ABCD;
    memBus.data_rdata = 32'h1111_2222;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("st_wait_req", memBus.data_req, 32'd1);
      chk("st_wait_addr", memBus.data_addr, 32'h8000_0020);
      chk("st_wait_wdata", memBus.data_wdata, 32'h0000_ABCD);
      chk("st_wait_wstrb", memBus.data_wstrb, 32'h3);
      chk("st_wait_wr", memBus.data_wr, 32'd1);
      chk("st_wait_size", memBus.data_size, 32'd1);
      step();
    end
    memBus.data_addr_ok = 1'b1;
    #1;
    chk("st_acc_addr", memBus.data_addr, 32'h8000_0020);
    chk("st_acc_wstrb", memBus.data_wstrb, 32'h3);
    step();
    memBus.data_addr_ok = 1'b0;
    chk("st_data_state", st(), 32'd2);
    chk("st_data_req", memBus.data_req, 32'd0);
    chk("st_data_stall", stall_memM, 32'd1);
    step();
    chk("st_data2_state", st(), 32'd2);
    chk("st_data2_wdata", memBus.data_wdata, 32'h0000_ABCD);
    memBus.data_data_ok = 1'b1;
    step();
    memBus.data_data_ok = 1'b0;
    chk("st_done_state", st(), 32'd3);
    chk("st_rd_unchanged", readdataM, 32'hDEAD_BEEF);
    memenM    = 1'b0;
    memwriteM = 1'b0;
    step();
    chk("st_back_idle", st(), 32'd0);

    // Load held in DONE by an external stall
    memenM    = 1'b1;
    sig_write = 4'b0000;
    sizeM     = SIZE_WORD;
    aluoutM   = 32'h8000_0030;
    memBus.data_addr_ok = 1'b1;
    memBus.data_data_ok = 1'b1;
    memBus.data_rdata   = 32'h1234_5678;
    step();
    step();
    chk("hold_rdata", readdataM, 32'h1234_5678);
    stall_extM = 1'b1;
    memBus.data_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      chk("hold_state", st(), 32'd3);
      chk("hold_stall", stall_memM, 32'd0);
      chk("hold_req", memBus.data_req, 32'd0);
      chk("hold_rd", readdataM, 32'h1234_5678);
      step();
    end
    chk("hold_still_done", st(), 32'd3);
    stall_extM = 1'b0;
    memenM     = 1'b0;
    memBus.data_addr_ok = 1'b0;
    memBus.data_data_ok = 1'b0;
    step();
    chk("hold_back_idle", st(), 32'd0);

    // Reset asserted while in DATA
    memenM  = 1'b1;
    aluoutM = 32'h8000_0040;
    step();
    memBus.data_addr_ok = 1'b1;
    step();
    memBus.data_addr_ok = 1'b0;
    chk("rd_in_data", st(), 32'd2);
    chk("rd_addr_held", memBus.data_addr, 32'h8000_0040);
    #2;
    rst = 1'b1;
    #1;
    chk("rd_async_state", st(), 32'd0);
    chk("rd_async_addr", memBus.data_addr, 32'd0);
    chk("rd_async_req", memBus.data_req, 32'd0);
    chk("rd_async_stall", stall_memM, 32'd0);
    chk("rd_async_rdata", readdataM, 32'd0);
    memenM = 1'b0;
    step();
    rst = 1'b0;
    memenM  = 1'b1;
    aluoutM = 32'h8000_0050;
    memBus.data_addr_ok = 1'b1;
    memBus.data_data_ok = 1'b1;
    memBus.data_rdata   = 32'hA5A5_A5A5;
    step();
    chk("rd_new_req", memBus.data_req, 32'd1);
    chk("rd_new_addr", memBus.data_addr, 32'h8000_0050);
    step();
    chk("rd_new_rdata", readdataM, 32'hA5A5_A5A5);
    memenM = 1'b0;
    memBus.data_addr_ok = 1'b0;
    memBus.data_data_ok = 1'b0;
    step();

    // memenM dropped while the address is outstanding
    memenM  = 1'b1;
    aluoutM = 32'h8000_0060;
    step();
    memenM = 1'b0;
    #1;
    chk("drop_req", memBus.data_req, 32'd1);
    chk("drop_stall", stall_memM, 32'd1);
    step();
    chk("drop_still_addr", st(), 32'd1);
    chk("drop_req2", memBus.data_req, 32'd1);
    memBus.data_addr_ok = 1'b1;
    step();
    memBus.data_addr_ok = 1'b0;
    memBus.data_data_ok = 1'b1;
    memBus.data_rdata   = 32'h0BAD_F00D;
    chk("drop_data", st(), 32'd2);
    step();
    memBus.data_data_ok = 1'b0;
    chk("drop_rdata", readdataM, 32'h0BAD_F00D);
    step();
    chk("drop_idle", st(), 32'd0);
    chk("drop_idle_stall", stall_memM, 32'd0);

    // Back-to-back loads with memenM held high
    memenM  = 1'b1;
    aluoutM = 32'h8000_0070;
    memBus.data_addr_ok = 1'b1;
    memBus.data_data_ok = 1'b1;
    memBus.data_rdata   = 32'h1111_1111;
    step();
    step();
    chk("b2b_rd1", readdataM, 32'h1111_1111);
    aluoutM = 32'h8000_0074;
    memBus.data_rdata = 32'h2222_2222;
    step();
    chk("b2b_idle", st(), 32'd0);
    chk("b2b_idle_req", memBus.data_req, 32'd0);
    chk("b2b_idle_stall", stall_memM, 32'd1);
    chk("b2b_idle_rd", readdataM, 32'h1111_1111);
    step();
    chk("b2b_req2", memBus.data_req, 32'd1);
    chk("b2b_addr2", memBus.data_addr, 32'h8000_0074);
    step();
    chk("b2b_rd2", readdataM, 32'h2222_2222);
    memenM = 1'b0;
    memBus.data_addr_ok = 1'b0;
    memBus.data_data_ok = 1'b0;
    step();
    chk("b2b_end_idle", st(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-003 SHALL have port memenM, input, 1, memory-stage load or store request.
REQ-004 SHALL have port memwriteM, input, 1, 1 = store, 0 = load.
REQ-005 SHALL have port sig_write, input, 4, byte write strobes for the store.
REQ-006 SHALL have port sizeM, input, 2, access size: 0 = byte, 1 = half, 2 = word.
REQ-007 SHALL have port aluoutM, input, 32, byte address.
REQ-008 SHALL have port writedataM, input, 32, store data, already lane-aligned.
REQ-009 SHALL have port stall_extM, input, 1, stall from elsewhere in the pipeline; holds the DONE state.
REQ-010 SHALL have ports data_req, data_wr, data_size[2], data_addr[32], data_wdata[32] and data_wstrb[4] as outputs; these form the bus request.
REQ-011 SHALL have ports data_addr_ok, data_data_ok and data_rdata[32] as inputs; these form the bus response.
REQ-012 SHALL have port readdataM, output, 32, captured load data.
REQ-013 SHALL have port stall_memM, output, 1, freezes the pipeline while an access is outstanding.

Function
REQ-014 SHALL implement the FSM states IDLE, ADDR, DATA and DONE, all registered.
REQ-015 SHALL, in IDLE with memenM=1, latch aluoutM, writedataM, memwriteM, sig_write and sizeM, then move to ADDR.
REQ-016 SHALL assert data_req only in ADDR, driving the latched fields; bus outputs stay stable until data_addr_ok is sampled high.
REQ-017 SHALL drive data_wstrb from the latched sig_write when data_wr=1, and drive it to 4'b0000 for loads.
REQ-018 SHALL, in ADDR, go to DATA on data_addr_ok=1 with data_data_ok=0; go to DONE on both high in the same cycle; stay in ADDR otherwise.
REQ-019 SHALL, in DATA, stay until data_data_ok=1, then go to DONE.
REQ-020 SHALL capture data_rdata into readdataM on the data_data_ok cycle for loads; stores leave readdataM unchanged.
REQ-021 SHALL, in DONE, go to IDLE when stall_extM=0 and hold DONE with readdataM stable when stall_extM=1; no new bus request is issued from DONE.
REQ-022 SHALL define stall_memM = (IDLE and memenM) or ADDR or DATA; it is 0 in DONE.
REQ-023 SHALL complete a bus transaction once data_req has been accepted, even if memenM falls; the request is never cancelled.
REQ-024 SHALL ignore data_data_ok in IDLE and DONE.
REQ-025 SHALL give minimum load latency of 3 cycles after memenM is sampled: IDLE, ADDR with both oks high, DONE.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-transaction, immediately force state to IDLE and set data_req, data_wr, data_wstrb, data_size, data_addr, data_wdata, readdataM and stall_memM to 0.
REQ-027 SHALL, after rst is released, start a new request only from IDLE on a clk edge.

Structure
REQ-028 SHALL place the FSM state encoding (2 bits) and the size constants (SIZE_BYTE, SIZE_HALF, SIZE_WORD) in a shared package, mem_pkg.
REQ-029 SHALL be a single module with no sub-modules.

Verification
REQ-030 SHALL cover word load: addr=0x80000010, addr_ok and data_ok in the same cycle, rdata=0xDEADBEEF -> readdataM=0xDEADBEEF in DONE; stall_memM high for exactly 2 cycles.
REQ-031 SHALL cover store with wait states: sig_write=4'b0011, wdata=0x0000ABCD, addr_ok delayed 3 cycles, data_ok 2 cycles later -> bus fields stable throughout, wstrb=0011, readdataM unchanged.
REQ-032 SHALL cover a load held in DONE: stall_extM=1 for 4 cycles -> state stays DONE, stall_memM=0, data_req=0, readdataM stable.
REQ-033 SHALL cover reset asserted in DATA -> outputs zero asynchronously; a subsequent load completes normally.
REQ-034 SHALL cover memenM dropped in ADDR -> data_req stays high until addr_ok, the transaction finishes and the FSM returns to IDLE.
REQ-035 SHALL cover back-to-back loads with memenM held high -> two separate requests, IDLE visited between them, both rdata values captured in order.
